// File: rtl/pipe_sb_pkg.sv
// Shared constants and types for the register-hazard scoreboard.
package pipe_sb_pkg;
  localparam int SB_LAT_W = 3;
  localparam logic [SB_LAT_W-1:0] LAT_LONG = '1;
  localparam logic [SB_LAT_W-1:0] LAT_ALU  = 3'd1;
  localparam logic [SB_LAT_W-1:0] LAT_LOAD = 3'd2;
  localparam logic [SB_LAT_W-1:0] LAT_JAL  = 3'd1;

  typedef struct packed {
    logic                busy;
    logic [SB_LAT_W-1:0] count;
  } sb_entry_t;
endpackage

// File: rtl/sb_entry.sv
// One register's pending-write state: fixed-latency countdown or variable-latency hold.
// SCOREBOARD_BYPASS_EN: a fixed entry at count 1 reports ready (result is on the bypass).
module sb_entry
  import pipe_sb_pkg::*;
#(
  parameter int LAT_W = SB_LAT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             issue,
  input  logic [LAT_W-1:0] issue_lat,
  input  logic             complete,
  input  logic             kill,
  output logic             busy,
  output logic             long_op,
  output logic             ready
);
  localparam logic [LAT_W-1:0] LONG = {LAT_W{1'b1}};

  logic             busy_q, busy_d;
  logic [LAT_W-1:0] count_q, count_d;
  logic             fixed;

  assign fixed = busy_q && (count_q != LONG);

  // Later assignments win: issue > complete/kill > aging.
  always_comb begin
    busy_d  = busy_q;
    count_d = count_q;
    if (fixed) begin
      count_d = count_q - 1'b1;
      if (count_q == LAT_W'(1)) busy_d = 1'b0;
    end
    if (complete && busy_q && !fixed) begin
      busy_d  = 1'b0;
      count_d = '0;
    end
    if (kill && fixed) begin
      busy_d  = 1'b0;
      count_d = '0;
    end
    if (issue) begin
      busy_d  = 1'b1;
      count_d = issue_lat;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy_q  <= 1'b0;
      count_q <= '0;
    end else begin
      busy_q  <= busy_d;
      count_q <= count_d;
    end
  end

  assign busy    = busy_q;
  assign long_op = busy_q && !fixed;
`ifdef SCOREBOARD_BYPASS_EN
  assign ready = !busy_q || (fixed && (count_q == LAT_W'(1)));
`else
  assign ready = !busy_q;
`endif
endmodule

// File: rtl/pipe_scoreboard.sv
// Register-hazard scoreboard: per-register entries, read-port hazard muxes and decode stall.
// SCOREBOARD_BYPASS_EN (in sb_entry) lets count==1 producers feed consumers without a stall.
module pipe_scoreboard
  import pipe_sb_pkg::*;
#(
  parameter int REG_BITS = 5,
  parameter int NUM_RD   = 2,
  parameter int LAT_W    = SB_LAT_W
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       issue_valid,
  input  logic                       issue_we,
  input  logic [REG_BITS-1:0]        issue_rd,
  input  logic [LAT_W-1:0]           issue_lat,
  input  logic [NUM_RD-1:0]          rs_valid,
  input  logic [NUM_RD*REG_BITS-1:0] rs_idx,
  input  logic                       complete_valid,
  input  logic [REG_BITS-1:0]        complete_rd,
  input  logic                       kill,
  output logic                       stall,
  output logic [NUM_RD-1:0]          rs_hazard,
  output logic                       issue_accept,
  output logic                       long_busy
);
  localparam int NREG = 2**REG_BITS;

  logic [NREG-1:0] busy, long_op, ready;
  logic            issue_go, waw;

  // Register 0 is hardwired empty.
  assign busy[0]    = 1'b0;
  assign long_op[0] = 1'b0;
  assign ready[0]   = 1'b1;

  assign issue_go = issue_accept && issue_we && (issue_rd != '0) &&
                    !kill && (issue_lat != '0);

  for (genvar r = 1; r < NREG; r++) begin : g_ent
    sb_entry #(.LAT_W(LAT_W)) u_ent (
      .clock     (clock),
      .reset     (reset),
      .issue     (issue_go && (issue_rd == REG_BITS'(r))),
      .issue_lat (issue_lat),
      .complete  (complete_valid && (complete_rd == REG_BITS'(r))),
      .kill      (kill),
      .busy      (busy[r]),
      .long_op   (long_op[r]),
      .ready     (ready[r])
    );
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [REG_BITS-1:0] idx;
    assign idx          = rs_idx[i*REG_BITS +: REG_BITS];
    assign rs_hazard[i] = rs_valid[i] && (idx != '0) && busy[idx] && !ready[idx];
  end

  assign waw          = issue_we && (issue_rd != '0) && long_op[issue_rd];
  assign stall        = issue_valid && ((|rs_hazard) || waw);
  assign issue_accept = issue_valid && !stall;
  assign long_busy    = |long_op;
endmodule

// File: tb/tb_pipe_scoreboard.sv
// Scenario bench for pipe_scoreboard: expected outputs queued per cycle, checked at negedge.
module tb_pipe_scoreboard;
  import pipe_sb_pkg::*;

`ifdef SCOREBOARD_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clock, reset;
  logic        issue_valid, issue_we;
  logic [4:0]  issue_rd;
  logic [2:0]  issue_lat;
  logic [1:0]  rs_valid;
  logic [9:0]  rs_idx;
  logic        complete_valid;
  logic [4:0]  complete_rd;
  logic        kill;
  logic        stall, issue_accept, long_busy;
  logic [1:0]  rs_hazard;

  logic [4:0]  exp_q[$];
  logic [4:0]  e, o;
  int          checks = 0;
  int          errs   = 0;

  pipe_scoreboard dut (
    .clock(clock), .reset(reset),
    .issue_valid(issue_valid), .issue_we(issue_we), .issue_rd(issue_rd), .issue_lat(issue_lat),
    .rs_valid(rs_valid), .rs_idx(rs_idx),
    .complete_valid(complete_valid), .complete_rd(complete_rd), .kill(kill),
    .stall(stall), .rs_hazard(rs_hazard), .issue_accept(issue_accept), .long_busy(long_busy)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic drv(input logic iv, input logic we, input logic [4:0] rd, input logic [2:0] lat,
                     input logic [1:0] rsv, input logic [4:0] r0, input logic [4:0] r1,
                     input logic cv, input logic [4:0] crd, input logic k);
    issue_valid = iv; issue_we = we; issue_rd = rd; issue_lat = lat;
    rs_valid = rsv; rs_idx = {r1, r0};
    complete_valid = cv; complete_rd = crd; kill = k;
  endtask

  // Expected vector layout: {stall, rs_hazard[1:0], issue_accept, long_busy}
  task automatic test_reset();
    reset = 1'b1;
    drv(1'b0, 1'b0, 5'd0, 3'd0, 2'b11, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0);
    exp_q.push_back(5'b0_00_0_0);
    @(negedge clock);
    e = exp_q.pop_front(); o = {stall, rs_hazard, issue_accept, long_busy}; checks++;
    if (o !== e) begin errs++; $display("FAIL reset got %b want %b", o, e); end
    reset = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic test_fixed();
    drv(1'b1, 1'b1, 5'd3, LAT_LOAD, 2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    exp_q.push_back(5'b0_00_1_0);
    @(negedge clock);
    e = exp_q.pop_front(); o = {stall, rs_hazard, issue_accept, long_busy}; checks++;
    if (o !== e) begin errs++; $display("FAIL fixed_issue got %b want %b", o, e); end
    @(posedge clock); #1;
    for (int k = 0; k < 3; k++) begin
      logic st;
      st = (k < (BYP ? 1 : 2));
      drv(1'b1, 1'b0, 5'd0, 3'd0, 2'b01, 5'd3, 5'd0, 1'b0, 5'd0, 1'b0);
      exp_q.push_back({st, 1'b0, st, !st, 1'b0});
      @(negedge clock);
      e = exp_q.pop_front(); o = {stall, rs_hazard, issue_accept, long_busy}; checks++;
      if (o !== e) begin errs++; $display("FAIL fixed_read[%0d] got %b want %b", k, o, e); end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_long();
    drv(1'b1, 1'b1, 5'd5, LAT_LONG, 2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    exp_q.push_back(5'b0_00_1_0);
    for (int k = 0; k < 20; k++) exp_q.push_back(5'b1_10_0_1);
    exp_q.push_back(5'b1_10_0_1);
    exp_q.push_back(5'b0_00_1_0);
    for (int k = 0; k < 23; k++) begin
      if (k > 0) drv(1'b1, 1'b0, 5'd0, 3'd0, 2'b10, 5'd0, 5'd5, (k == 21), 5'd5, 1'b0);
      @(negedge clock);
      e = exp_q.pop_front(); o = {stall, rs_hazard, issue_accept, long_busy}; checks++;
      if (o !== e) begin errs++; $display("FAIL long[%0d] got %b want %b", k, o, e); end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_r0();
    for (int k = 0; k < 4; k++) begin
      drv(1'b1, 1'b1, 5'd0, 3'd3, (k == 0) ? 2'b00 : 2'b11, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0);
      exp_q.push_back(5'b0_00_1_0);
      @(negedge clock);
      e = exp_q.pop_front(); o = {stall, rs_hazard, issue_accept, long_busy}; checks++;
      if (o !== e) begin errs++; $display("FAIL r0[%0d] got %b want %b", k, o, e); end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_waw();
    logic st;
    st = !BYP;
    exp_q.push_back(5'b0_00_1_0);
    exp_q.push_back(5'b1_00_0_1);
    exp_q.push_back(5'b1_00_0_1);
    exp_q.push_back(5'b0_00_1_0);
    exp_q.push_back({st, 1'b0, st, !st, 1'b0});
    exp_q.push_back(5'b0_00_0_0);
    for (int k = 0; k < 6; k++) begin
      case (k)
        0: drv(1'b1, 1'b1, 5'd7, LAT_LONG, 2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        1: drv(1'b1, 1'b1, 5'd7, LAT_ALU,  2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        2: drv(1'b1, 1'b1, 5'd7, LAT_ALU,  2'b00, 5'd0, 5'd0, 1'b1, 5'd7, 1'b0);
        3: drv(1'b1, 1'b1, 5'd7, LAT_ALU,  2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        4: drv(1'b1, 1'b0, 5'd0, 3'd0,     2'b01, 5'd7, 5'd0, 1'b0, 5'd0, 1'b0);
        default: drv(1'b0, 1'b0, 5'd0, 3'd0, 2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
      endcase
      @(negedge clock);
      e = exp_q.pop_front(); o = {stall, rs_hazard, issue_accept, long_busy}; checks++;
      if (o !== e) begin errs++; $display("FAIL waw[%0d] got %b want %b", k, o, e); end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_kill();
    exp_q.push_back(5'b0_00_1_0);
    exp_q.push_back(5'b0_00_1_0);
    exp_q.push_back(5'b0_00_1_1);
    exp_q.push_back(5'b1_10_0_1);
    exp_q.push_back(5'b0_00_1_1);
    exp_q.push_back(5'b0_00_0_1);
    exp_q.push_back(5'b0_00_0_0);
    for (int k = 0; k < 7; k++) begin
      case (k)
        0: drv(1'b1, 1'b1, 5'd4, 3'd3,     2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        1: drv(1'b1, 1'b1, 5'd6, LAT_LONG, 2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        2: drv(1'b1, 1'b1, 5'd9, 3'd3,     2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1);
        3: drv(1'b1, 1'b0, 5'd0, 3'd0,     2'b11, 5'd4, 5'd6, 1'b0, 5'd0, 1'b0);
        4: drv(1'b1, 1'b0, 5'd0, 3'd0,     2'b01, 5'd9, 5'd0, 1'b0, 5'd0, 1'b0);
        5: drv(1'b0, 1'b0, 5'd0, 3'd0,     2'b00, 5'd0, 5'd0, 1'b1, 5'd6, 1'b0);
        default: drv(1'b0, 1'b0, 5'd0, 3'd0, 2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
      endcase
      @(negedge clock);
      e = exp_q.pop_front(); o = {stall, rs_hazard, issue_accept, long_busy}; checks++;
      if (o !== e) begin errs++; $display("FAIL kill[%0d] got %b want %b", k, o, e); end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_reset_mid();
    exp_q.push_back(5'b0_00_1_0);
    exp_q.push_back(5'b1_01_0_1);
    exp_q.push_back(5'b0_00_0_0);
    exp_q.push_back(5'b0_00_0_0);
    exp_q.push_back(5'b0_00_1_0);
    for (int k = 0; k < 5; k++) begin
      case (k)
        0: drv(1'b1, 1'b1, 5'd2, LAT_LONG, 2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        1: drv(1'b1, 1'b0, 5'd0, 3'd0,     2'b01, 5'd2, 5'd0, 1'b0, 5'd0, 1'b0);
        2: begin
          drv(1'b0, 1'b0, 5'd0, 3'd0, 2'b01, 5'd2, 5'd0, 1'b0, 5'd0, 1'b0);
          #1 reset = 1'b1;
        end
        3: drv(1'b0, 1'b0, 5'd0, 3'd0, 2'b00, 5'd0, 5'd0, 1'b1, 5'd2, 1'b0);
        default: drv(1'b1, 1'b1, 5'd2, LAT_JAL, 2'b01, 5'd2, 5'd0, 1'b0, 5'd0, 1'b0);
      endcase
      @(negedge clock);
      e = exp_q.pop_front(); o = {stall, rs_hazard, issue_accept, long_busy}; checks++;
      if (o !== e) begin errs++; $display("FAIL reset_mid[%0d] got %b want %b", k, o, e); end
      #1 reset = 1'b0;
      @(posedge clock); #1;
    end
    drv(1'b0, 1'b0, 5'd0, 3'd0, 2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    drv(1'b0, 1'b0, 5'd0, 3'd0, 2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    @(posedge clock); #1;
    test_reset();
    test_fixed();
    test_long();
    test_r0();
    test_waw();
    test_kill();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
    $finish;
  end
endmodule
